// File: rtl/draw_screen_image.sv
// Full-screen raster image drawer: sweeps every pixel, fetches colour from a
// synchronous ROM and emits one registered plot per cycle, then pulses done.
module draw_screen_image #(
   parameter int WIDTH  = 160,
   parameter int HEIGHT = 120,
   parameter int ADDR_W = 15
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              start,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [2:0]        rom_data,
   output logic              plot,
   output logic [7:0]        x,
   output logic [6:0]        y,
   output logic [2:0]        col,
   output logic              busy,
   output logic              done
);

   localparam logic [7:0]        XMAX = 8'(WIDTH - 1);
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(WIDTH * HEIGHT - 1);

   typedef enum logic [1:0] {IDLE, SWEEP, FLUSH, DONE} state_t;

   state_t            state_q;
   logic              start_q;
   logic              rise, abort, xwrap, last;
   logic [7:0]        xc_q, xc_d;
   logic [6:0]        yc_q, yc_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        x1_q;
   logic [6:0]        y1_q;
   logic              v1_q;
   logic              fl_q;
   logic              plot_q, busy_q, done_q;
   logic [7:0]        x_q;
   logic [6:0]        y_q;
   logic [2:0]        col_q;

   always_comb begin
      rise   = start & ~start_q;
      abort  = ~start & ((state_q == SWEEP) || (state_q == FLUSH));
      xwrap  = (xc_q == XMAX);
      last   = (addr_q == LAST);
      xc_d   = xwrap ? 8'd0 : xc_q + 8'd1;
      yc_d   = xwrap ? yc_q + 7'd1 : yc_q;
      addr_d = addr_q + ADDR_W'(1);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         start_q <= 1'b0;
         xc_q    <= '0;
         yc_q    <= '0;
         addr_q  <= '0;
         x1_q    <= '0;
         y1_q    <= '0;
         v1_q    <= 1'b0;
         fl_q    <= 1'b0;
         plot_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
         col_q   <= '0;
      end else begin
         start_q <= start;
         v1_q    <= 1'b0;
         done_q  <= 1'b0;
         // stage 2: an abort kills the pixel already in flight
         plot_q  <= v1_q & ~abort;
         if (v1_q && !abort) begin
            x_q   <= x1_q;
            y_q   <= y1_q;
            col_q <= rom_data;
         end
         if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
         end else begin
            unique case (state_q)
               IDLE: begin
                  if (rise) begin
                     state_q <= SWEEP;
                     busy_q  <= 1'b1;
                     xc_q    <= '0;
                     yc_q    <= '0;
                     addr_q  <= '0;
                  end
               end
               SWEEP: begin
                  v1_q <= 1'b1;
                  x1_q <= xc_q;
                  y1_q <= yc_q;
                  if (last) begin
                     state_q <= FLUSH;
                     fl_q    <= 1'b0;
                  end else begin
                     xc_q   <= xc_d;
                     yc_q   <= yc_d;
                     addr_q <= addr_d;
                  end
               end
               FLUSH: begin
                  fl_q <= 1'b1;
                  if (fl_q) begin
                     state_q <= DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end
               DONE: begin
                  state_q <= IDLE;
               end
               default: begin
                  state_q <= IDLE;
               end
            endcase
         end
      end
   end

   assign rom_addr = addr_q;
   assign plot     = plot_q;
   assign x        = x_q;
   assign y        = y_q;
   assign col      = col_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_draw_screen_image.sv
// Bench for draw_screen_image: a 4x3 instance and a default 160x120 instance
// fed by synchronous ROM models, with an expected-pixel queue per sweep.
module tb_draw_screen_image;

   logic        clk = 1'b0;
   logic        resetn;
   logic        s_start, d_start;
   logic [3:0]  s_ra;
   logic [14:0] d_ra;
   logic [2:0]  s_rd, d_rd;
   logic        s_plot, s_busy, s_done;
   logic        d_plot, d_busy, d_done;
   logic [7:0]  s_x, d_x;
   logic [6:0]  s_y, d_y;
   logic [2:0]  s_col, d_col;

   int vectors = 0;
   int errors  = 0;
   logic [31:0] q[$];

   always #5 clk = ~clk;

   always_ff @(posedge clk) begin
      s_rd <= s_ra[2:0];
      d_rd <= d_ra[2:0];
   end

   draw_screen_image #(.WIDTH(4), .HEIGHT(3), .ADDR_W(4)) u_s (
      .clk(clk), .resetn(resetn), .start(s_start), .rom_addr(s_ra),
      .rom_data(s_rd), .plot(s_plot), .x(s_x), .y(s_y), .col(s_col),
      .busy(s_busy), .done(s_done));

   draw_screen_image u_d (
      .clk(clk), .resetn(resetn), .start(d_start), .rom_addr(d_ra),
      .rom_data(d_rd), .plot(d_plot), .x(d_x), .y(d_y), .col(d_col),
      .busy(d_busy), .done(d_done));

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_chk(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk("idle s_plot", 32'(s_plot), 0);
         chk("idle s_busy", 32'(s_busy), 0);
         chk("idle s_done", 32'(s_done), 0);
         chk("idle d_plot", 32'(d_plot), 0);
         chk("idle d_done", 32'(d_done), 0);
      end
   endtask

   // Called at a negedge; that cycle is cycle 0 of the sweep.
   task automatic sweep(input bit big, input int W, input int H,
                        input int cut, input bit rst);
      int n, last;
      logic [31:0] p, b, d, ra, pix, e;
      bit pexp, pchk;
      n    = W * H;
      last = (cut > 0) ? cut + 12 : n + 6;
      q.delete();
      for (int yy = 0; yy < H; yy++)
         for (int xx = 0; xx < W; xx++)
            q.push_back({14'd0, 8'(xx), 7'(yy), 3'((yy * W + xx) % 8)});
      if (big) d_start = 1'b1; else s_start = 1'b1;
      for (int c = 1; c <= last; c++) begin
         @(negedge clk);
         p   = big ? 32'(d_plot) : 32'(s_plot);
         b   = big ? 32'(d_busy) : 32'(s_busy);
         d   = big ? 32'(d_done) : 32'(s_done);
         ra  = big ? 32'(d_ra) : 32'(s_ra);
         pix = big ? {14'd0, d_x, d_y, d_col} : {14'd0, s_x, s_y, s_col};
         pexp = (c >= 3) && (c <= n + 2) && (cut == 0 || c <= cut);
         pchk = !(cut > 0 && c == cut + 1);
         if (pchk) begin
            chk("plot", p, 32'(pexp));
            chk("busy", b, 32'((c <= n + 2) && (cut == 0 || c <= cut)));
         end
         chk("done", d, 32'(cut == 0 && c == n + 3));
         if (c <= n && (cut == 0 || c <= cut))
            chk("rom_addr", ra, 32'(c - 1));
         if (p == 1 && q.size() > 0) begin
            e = q.pop_front();
            if (pchk) chk("pixel", pix, e);
         end
         if (cut > 0 && c == cut) begin
            if (rst) begin
               #1 resetn = 1'b0;
               #1;
               chk("rst plot", 32'(s_plot), 0);
               chk("rst busy", 32'(s_busy), 0);
               chk("rst done", 32'(s_done), 0);
               chk("rst xyc", {14'd0, s_x, s_y, s_col}, 0);
               chk("rst rom_addr", 32'(s_ra), 0);
               @(negedge clk);
               s_start = 1'b0;
               @(negedge clk);
               resetn = 1'b1;
               break;
            end else begin
               if (big) d_start = 1'b0; else s_start = 1'b0;
            end
         end
      end
      if (cut == 0) begin
         chk("all pixels plotted", 32'(q.size()), 0);
         chk("hold xy", big ? {24'd0, d_x} : {24'd0, s_x}, 32'(W - 1));
      end
      q.delete();
   endtask

   initial begin
      resetn  = 1'b0;
      s_start = 1'b0;
      d_start = 1'b0;
      #1;
      chk("reset s_plot", 32'(s_plot), 0);
      chk("reset d_ra", 32'(d_ra), 0);
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("idle outs", {14'd0, s_x, s_y, s_col}, 0);
         chk("idle flags", {29'd0, s_plot, s_busy, s_done}, 0);
         chk("idle s_ra", 32'(s_ra), 0);
         chk("idle d_ra", 32'(d_ra), 0);
         chk("idle d_flags", {29'd0, d_plot, d_busy, d_done}, 0);
      end

      sweep(1'b0, 4, 3, 0, 1'b0);
      s_start = 1'b0;
      @(negedge clk);
      sweep(1'b0, 4, 3, 0, 1'b0);

      s_start = 1'b0;
      @(negedge clk);
      sweep(1'b0, 4, 3, 6, 1'b0);
      sweep(1'b0, 4, 3, 0, 1'b0);

      s_start = 1'b0;
      @(negedge clk);
      sweep(1'b0, 4, 3, 7, 1'b1);
      idle_chk(10);
      sweep(1'b0, 4, 3, 0, 1'b0);
      s_start = 1'b0;

      @(negedge clk);
      sweep(1'b1, 160, 120, 0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("held start d_flags", {29'd0, d_plot, d_busy, d_done}, 0);
      end
      chk("final y", 32'(d_y), 119);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
